// File: rtl/peak_tracker.sv
// peak_tracker: windowed max/min tracker with x/y/z trend flags and valid/ready handshakes.
// Define PEAK_TRACKER_TREND_EN to add saturating per-window rise_cnt/fall_cnt outputs.
module peak_tracker #(
  parameter int WIDTH  = 4,
  parameter int WINDOW = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             x,
  output logic             y,
  output logic             z,
  output logic [WIDTH-1:0] max_out,
  output logic [WIDTH-1:0] min_out,
  output logic             out_valid,
  input  logic             out_ready
`ifdef PEAK_TRACKER_TREND_EN
  ,
  output logic [7:0]       rise_cnt,
  output logic [7:0]       fall_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
  state_t           state;
  logic [7:0]       count;
  logic [WIDTH-1:0] prev;
  assign in_ready = state != HOLD;
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      max_out   <= '0;
      min_out   <= '0;
      prev      <= '0;
      {x, y, z} <= '0;
      out_valid <= 1'b0;
`ifdef PEAK_TRACKER_TREND_EN
      rise_cnt  <= '0;
      fall_cnt  <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          max_out <= din;
          min_out <= din;
          prev    <= din;
          count   <= 8'd1;
          state   <= ACCUM;
        end
        ACCUM: if (in_valid) begin
          if (din > max_out) max_out <= din;
          if (din < min_out) min_out <= din;
          prev  <= din;
          count <= count + 8'd1;
          x     <= din > prev;
          y     <= din == prev;
          z     <= din < prev;
`ifdef PEAK_TRACKER_TREND_EN
          if (din > prev && rise_cnt != 8'hFF) rise_cnt <= rise_cnt + 8'd1;
          if (din < prev && fall_cnt != 8'hFF) fall_cnt <= fall_cnt + 8'd1;
`endif
          // this sample completes the window
          if (count == 8'(WINDOW - 1)) begin
            state     <= HOLD;
            out_valid <= 1'b1;
          end
        end
        HOLD: if (out_ready) begin
          state     <= IDLE;
          out_valid <= 1'b0;
          count     <= '0;
          {x, y, z} <= '0;
`ifdef PEAK_TRACKER_TREND_EN
          rise_cnt  <= '0;
          fall_cnt  <= '0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_peak_tracker.sv
// tb_peak_tracker: scenario tasks plus randomized run against a queue-based window model.
module tb_peak_tracker;
  localparam int W = 4;
  localparam int N = 8;
  logic clk = 1'b0;
  logic rst, in_valid, out_ready;
  logic [W-1:0] din;
  logic in_ready, x, y, z, out_valid;
  logic [W-1:0] max_out, min_out;
`ifdef PEAK_TRACKER_TREND_EN
  logic [7:0] rise_cnt, fall_cnt;
`endif
  int n_cmp = 0;
  int n_bad = 0;
  int q[$];
  bit m_hold;
  bit [2:0] m_xyz;
  int m_max, m_min, m_rise, m_fall;

  peak_tracker #(.WIDTH(W), .WINDOW(N)) dut (
    .clk(clk), .rst(rst), .din(din), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .z(z), .max_out(max_out), .min_out(min_out),
    .out_valid(out_valid), .out_ready(out_ready)
`ifdef PEAK_TRACKER_TREND_EN
    , .rise_cnt(rise_cnt), .fall_cnt(fall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Drive one cycle and advance the window model at the same edge; outputs are read at the next negedge.
  task automatic step(input bit r, input bit v, input int d, input bit o);
    rst = r; in_valid = v; din = d[W-1:0]; out_ready = o;
    @(posedge clk);
    if (r) begin
      q.delete(); m_hold = 0; m_xyz = 0; m_max = 0; m_min = 0; m_rise = 0; m_fall = 0;
    end else if (m_hold) begin
      if (o) begin q.delete(); m_hold = 0; m_xyz = 0; m_rise = 0; m_fall = 0; end
    end else if (v) begin
      if (q.size() > 0) begin
        m_xyz = {d > q[$], d == q[$], d < q[$]};
        if (d > q[$]) m_rise = m_rise < 255 ? m_rise + 1 : 255;
        if (d < q[$]) m_fall = m_fall < 255 ? m_fall + 1 : 255;
      end
      q.push_back(d);
      m_max = q[0]; m_min = q[0];
      foreach (q[i]) begin
        if (q[i] > m_max) m_max = q[i];
        if (q[i] < m_min) m_min = q[i];
      end
      if (q.size() == N) m_hold = 1;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0);
    step(1, 1, 9, 1);
    step(0, 0, 0, 0);
    n_cmp++; if ({max_out, min_out} !== '0) begin n_bad++; $display("FAIL reset_maxmin: got %0d/%0d want 0/0", max_out, min_out); end
    n_cmp++; if ({x, y, z, out_valid} !== 4'b0000) begin n_bad++; $display("FAIL reset_flags: got xyz=%b ov=%b want 000/0", {x, y, z}, out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_basic();
    int s[8] = '{3, 7, 7, 1, 9, 0, 4, 2};
    bit [2:0] want[8] = '{3'b000, 3'b100, 3'b010, 3'b001, 3'b100, 3'b001, 3'b100, 3'b001};
    for (int i = 0; i < 8; i++) begin
      step(0, 1, s[i], 0);
      n_cmp++; if ({x, y, z} !== want[i]) begin n_bad++; $display("FAIL basic_xyz[%0d]: got %b want %b", i, {x, y, z}, want[i]); end
      if (i < 7) begin
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_early_valid[%0d]: got %b want 0", i, out_valid); end
      end
    end
    n_cmp++; if ({out_valid, max_out, min_out} !== {1'b1, 4'd9, 4'd0}) begin n_bad++; $display("FAIL basic_result: got ov=%b max=%0d min=%0d want 1/9/0", out_valid, max_out, min_out); end
    step(0, 0, 0, 1);
    n_cmp++; if ({out_valid, in_ready, x, y, z} !== 5'b01000) begin n_bad++; $display("FAIL basic_release: got ov=%b ir=%b xyz=%b want 0/1/000", out_valid, in_ready, {x, y, z}); end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] hmax, hmin;
    for (int i = 0; i < N; i++) step(0, 1, $urandom_range(0, 15), 0);
    hmax = m_max[W-1:0]; hmin = m_min[W-1:0];
    n_cmp++; if ({max_out, min_out} !== {hmax, hmin}) begin n_bad++; $display("FAIL bp_result: got %0d/%0d want %0d/%0d", max_out, min_out, hmax, hmin); end
    for (int i = 0; i < 5; i++) begin
      step(0, 1, $urandom_range(0, 15), 0);
      n_cmp++; if ({in_ready, out_valid, max_out, min_out} !== {1'b0, 1'b1, hmax, hmin}) begin n_bad++; $display("FAIL bp_hold[%0d]: got ir=%b ov=%b %0d/%0d want 0/1 %0d/%0d", i, in_ready, out_valid, max_out, min_out, hmax, hmin); end
    end
    step(0, 1, 3, 1);
    n_cmp++; if ({in_ready, out_valid} !== 2'b10) begin n_bad++; $display("FAIL bp_release: got ir=%b ov=%b want 1/0", in_ready, out_valid); end
    step(0, 1, 5, 0);
    n_cmp++; if ({max_out, min_out} !== {4'd5, 4'd5}) begin n_bad++; $display("FAIL bp_first_after: got %0d/%0d want 5/5", max_out, min_out); end
    for (int i = 1; i < N; i++) step(0, 1, 5, 0);
    step(0, 0, 0, 1);
  endtask

  task automatic test_gaps();
    int s[8] = '{3, 7, 7, 1, 9, 0, 4, 2};
    for (int i = 0; i < 8; i++) begin
      step(0, 1, s[i], 0);
      for (int g = 0; g < 3 && i < 7; g++) step(0, 0, 15, 0);
      if (i == 6) begin
        n_cmp++; if ({out_valid, in_ready, max_out, min_out} !== {1'b0, 1'b1, 4'd9, 4'd0}) begin n_bad++; $display("FAIL gaps_live: got ov=%b ir=%b %0d/%0d want 0/1 9/0", out_valid, in_ready, max_out, min_out); end
      end
    end
    n_cmp++; if ({out_valid, max_out, min_out} !== {1'b1, 4'd9, 4'd0}) begin n_bad++; $display("FAIL gaps_result: got ov=%b %0d/%0d want 1 9/0", out_valid, max_out, min_out); end
    step(0, 0, 0, 1);
  endtask

  task automatic test_mid_reset();
    int s[8] = '{5, 6, 4, 8, 3, 7, 6, 5};
    step(0, 1, 15, 0); step(0, 1, 0, 0); step(0, 1, 15, 0); step(0, 1, 0, 0);
    step(1, 1, 7, 1);
    n_cmp++; if ({max_out, min_out, x, y, z, out_valid, in_ready} !== {8'd0, 5'b00001}) begin n_bad++; $display("FAIL midrst_clear: got %0d/%0d xyz=%b ov=%b ir=%b want 0/0 000 0 1", max_out, min_out, {x, y, z}, out_valid, in_ready); end
    for (int i = 0; i < 8; i++) begin
      step(0, 1, s[i], 0);
      if (i == 6) begin
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_early_valid: got %b want 0", out_valid); end
      end
    end
    n_cmp++; if ({out_valid, max_out, min_out} !== {1'b1, 4'd8, 4'd3}) begin n_bad++; $display("FAIL midrst_result: got ov=%b %0d/%0d want 1 8/3", out_valid, max_out, min_out); end
    step(0, 0, 0, 1);
  endtask

  task automatic test_all_equal();
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 15, 0);
      if (i == 1) begin
        n_cmp++; if ({x, y, z} !== 3'b010) begin n_bad++; $display("FAIL eq_xyz: got %b want 010", {x, y, z}); end
      end
    end
    n_cmp++; if ({out_valid, max_out, min_out} !== {1'b1, 4'd15, 4'd15}) begin n_bad++; $display("FAIL eq_result: got ov=%b %0d/%0d want 1 15/15", out_valid, max_out, min_out); end
`ifdef PEAK_TRACKER_TREND_EN
    n_cmp++; if ({rise_cnt, fall_cnt} !== 16'h0) begin n_bad++; $display("FAIL eq_trend: got %0d/%0d want 0/0", rise_cnt, fall_cnt); end
`endif
    step(0, 0, 0, 1);
  endtask

`ifdef PEAK_TRACKER_TREND_EN
  task automatic test_trend();
    int s[8] = '{0, 1, 2, 3, 2, 1, 0, 5};
    for (int i = 0; i < 8; i++) step(0, 1, s[i], 0);
    n_cmp++; if ({rise_cnt, fall_cnt} !== {8'd4, 8'd3}) begin n_bad++; $display("FAIL trend_counts: got %0d/%0d want 4/3", rise_cnt, fall_cnt); end
    step(0, 0, 0, 1);
    n_cmp++; if ({rise_cnt, fall_cnt} !== 16'h0) begin n_bad++; $display("FAIL trend_clear: got %0d/%0d want 0/0", rise_cnt, fall_cnt); end
  endtask
`endif

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 15), $urandom_range(0, 2) == 0);
      n_cmp++;
      if ({in_ready, out_valid, max_out, min_out, x, y, z} !== {!m_hold, m_hold, m_max[W-1:0], m_min[W-1:0], m_xyz}) begin
        n_bad++;
        $display("FAIL rand[%0d]: got ir=%b ov=%b %0d/%0d xyz=%b want %b %b %0d/%0d %b", c, in_ready, out_valid, max_out, min_out, {x, y, z}, !m_hold, m_hold, m_max, m_min, m_xyz);
      end
`ifdef PEAK_TRACKER_TREND_EN
      n_cmp++;
      if ({rise_cnt, fall_cnt} !== {m_rise[7:0], m_fall[7:0]}) begin n_bad++; $display("FAIL rand_trend[%0d]: got %0d/%0d want %0d/%0d", c, rise_cnt, fall_cnt, m_rise, m_fall); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_gaps();
    test_mid_reset();
    test_all_equal();
`ifdef PEAK_TRACKER_TREND_EN
    test_trend();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/peak_tracker.md
PEAK_TRACKER -- requirements
Module: peak_tracker

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the sample width in bits.
REQ-002 The block SHALL have parameter WINDOW, default 8, giving the number of samples per window (legal range 2..255).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port din, input, WIDTH bits: unsigned sample value.
REQ-006 The block SHALL have port in_valid, input, 1 bit: din is valid this cycle.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts a sample this cycle.
REQ-008 The block SHALL have port x, output, 1 bit: the last accepted sample is greater than the previous one.
REQ-009 The block SHALL have port y, output, 1 bit: the last accepted sample equals the previous one.
REQ-010 The block SHALL have port z, output, 1 bit: the last accepted sample is less than the previous one.
REQ-011 The block SHALL have port max_out, output, WIDTH bits: the window maximum.
REQ-012 The block SHALL have port min_out, output, WIDTH bits: the window minimum.
REQ-013 The block SHALL have port out_valid, output, 1 bit: max_out and min_out hold a completed window.
REQ-014 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result.

Function
REQ-015 The FSM SHALL have three states: IDLE, ACCUM and HOLD.
REQ-016 A sample SHALL be accepted only when in_valid and in_ready are both high in the same cycle.
REQ-017 in_ready SHALL be high in IDLE and ACCUM and low in HOLD.
REQ-018 In IDLE, an accepted sample SHALL load max and min with din, set count to 1, keep x/y/z at 0 and move the FSM to ACCUM.
REQ-019 In ACCUM, each accepted sample SHALL update max (if din > max), update min (if din < min) and increment count; ties SHALL leave max and min unchanged.
REQ-020 On each accepted sample after the first in a window, x/y/z SHALL be registered one cycle after acceptance as one-hot unsigned comparisons of din against the previous accepted sample; they SHALL hold their value until the next acceptance.
REQ-021 The sample that makes count equal WINDOW SHALL be included in max/min, and the FSM SHALL enter HOLD with out_valid high on the next cycle (latency 1 cycle from the last acceptance).
REQ-022 In HOLD, max_out, min_out and out_valid SHALL stay stable until out_ready is high.
REQ-023 When out_valid and out_ready are both high, the FSM SHALL go to IDLE next cycle with out_valid low, and x/y/z SHALL clear to 0.
REQ-024 in_valid SHALL be ignored while in HOLD, so no sample is lost or counted.
REQ-025 Cycles in ACCUM with in_valid low SHALL change no state.
REQ-026 max_out and min_out SHALL show the live running values in ACCUM and the frozen values in HOLD.

Reset
REQ-027 When rst is high at a clock edge, the block SHALL set FSM=IDLE, count=0, max_out=0, min_out=0, x=y=z=0 and out_valid=0; in_ready SHALL be 1 in the cycle after reset.
REQ-028 rst SHALL take priority over every handshake in the same cycle, including mid-window and during HOLD; partial window contents SHALL be discarded.

Configuration
REQ-029 When macro PEAK_TRACKER_TREND_EN is defined, the block SHALL add outputs rise_cnt and fall_cnt, each 8 bits.
REQ-030 With PEAK_TRACKER_TREND_EN, rise_cnt and fall_cnt SHALL count x and z events in the current window, saturate at 255, reset to 0 and clear on the output handshake.
REQ-031 Without PEAK_TRACKER_TREND_EN, these ports and counters SHALL be absent and the block's behaviour SHALL otherwise be identical.

Verification
REQ-032 The bench SHALL cover: rst, then samples 3,7,7,1,9,0,4,2 with continuous in_valid -> out_valid after the 8th sample, max_out=9, min_out=0; x/y/z after the 2nd sample = 1/0/0, after the 3rd = 0/1/0, after the 4th = 0/0/1.
REQ-033 The bench SHALL cover: a full window with out_ready low for 5 cycles while in_valid stays high -> in_ready=0, outputs stable, no sample counted; out_ready pulse -> IDLE next cycle.
REQ-034 The bench SHALL cover: in_valid gaps of 3 idle cycles between samples -> same max/min as the gap-free run.
REQ-035 The bench SHALL cover: rst asserted after 4 samples -> all outputs 0; a following full window of 8 samples yields the correct result, unaffected by the discarded samples.
REQ-036 The bench SHALL cover: all samples equal to 4'hF -> max_out=min_out=15, y=1 after the 2nd sample; with PEAK_TRACKER_TREND_EN, rise_cnt=0 and fall_cnt=0.
REQ-037 The bench SHALL cover, with PEAK_TRACKER_TREND_EN: samples 0,1,2,3,2,1,0,5 -> rise_cnt=4, fall_cnt=3.
